p_multiplier: RTL and testbench

Sequential (shift-add, radix-2) WIDTH x WIDTH multiplier producing a 2*WIDTH-bit product.
One instance per partial product in the matrix-multiply array; each instance computes A[i][k]*B[k][j] and feeds the adder tree.

---
 rtl/p_mult_pkg.sv | 24 ++
 rtl/p_multiplier_if.sv | 38 +++
 rtl/p_mult_datapath.sv | 110 +++++++++++
 rtl/p_multiplier.sv | 98 +++++++++
 tb/tb_p_multiplier.sv | 133 +++++++++++++
 5 files changed

// File: rtl/p_mult_pkg.sv
// ----------------------------------------------------------------------------
// p_mult_pkg
// Shared definitions for the shift-add multiplier:
//   - state_t       : controller states IDLE / BUSY / DONE
//   - DEFAULT_WIDTH : default operand width, also used by the matrix top
//   - cnt_width()   : bit counter width, clog2(width)+1, so the counter can
//                     hold the value WIDTH itself without wrapping
// Optional feature macro: P_MULT_SIGNED_EN (consumed by p_mult_datapath).
// ----------------------------------------------------------------------------
package p_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/p_multiplier_if.sv
// ----------------------------------------------------------------------------
// p_multiplier_if
// Handshake/operand bundle of one multiplier instance.
//   input_ready  : operands valid / start request (level), master -> slave
//   a, b         : multiplicand / multiplier, master -> slave
//   output_ready : product valid while a finished result is held, slave -> master
//   product      : registered 2*WIDTH-bit result, slave -> master
// Modports: master (requester, e.g. matrix array or bench), slave (multiplier).
// ----------------------------------------------------------------------------
interface p_multiplier_if
  import p_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                   input_ready;
  logic                   output_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output input_ready,
    output a,
    output b,
    input  output_ready,
    input  product
  );

  modport slave (
    input  input_ready,
    input  a,
    input  b,
    output output_ready,
    output product
  );

endinterface

// File: rtl/p_mult_datapath.sv
// ----------------------------------------------------------------------------
// p_mult_datapath
// Radix-2 shift-add datapath: operand registers, accumulator, bit counter and
// the product register. Sequencing comes from the FSM in p_multiplier.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   i_start     : capture operands, clear accumulator and counter
//   i_step      : perform one add/shift iteration
//   i_a, i_b    : operands (sampled only while i_start is high)
//   o_last      : current iteration is the final one (count == WIDTH-1)
//   o_product   : registered result, updated only on the final iteration
// Macro P_MULT_SIGNED_EN: two's complement operands. The multiplicand is
// sign-extended and the partial product of the multiplier MSB is subtracted,
// since that bit carries weight -2^(WIDTH-1).
// ----------------------------------------------------------------------------
module p_mult_datapath
  import p_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_last,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_product;

  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_sum;

  // Extend the multiplicand to full product width.
  always_comb begin
    w_a_ext = {{WIDTH{1'b0}}, i_a};
`ifdef P_MULT_SIGNED_EN
    w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
`else
    w_a_ext = {{WIDTH{1'b0}}, i_a};
`endif
  end

  // Final-iteration flag for the controller.
  always_comb begin
    o_last = (r_cnt == CW'(WIDTH - 1));
  end

  // Partial product selection and accumulate (subtract on signed MSB step).
  always_comb begin
    w_addend = {PW{1'b0}};
    w_sum    = r_acc;
    if (r_mplier[0]) begin
      w_addend = r_mcand;
    end else begin
      w_addend = {PW{1'b0}};
    end
`ifdef P_MULT_SIGNED_EN
    if (o_last) begin
      w_sum = r_acc - w_addend;
    end else begin
      w_sum = r_acc + w_addend;
    end
`else
    w_sum = r_acc + w_addend;
`endif
  end

  // Operand, accumulator and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand  <= {PW{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (i_start) begin
      r_mcand  <= w_a_ext;
      r_mplier <= i_b;
      r_acc    <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (i_step) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_sum;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Product register: written only when the last partial product lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_product <= {PW{1'b0}};
    end else if (i_step && o_last) begin
      r_product <= w_sum;
    end
  end

  assign o_product = r_product;

endmodule

// File: rtl/p_multiplier.sv
// ----------------------------------------------------------------------------
// p_multiplier
// Sequential WIDTH x WIDTH shift-add multiplier with a level handshake.
// Ports:
//   clk    : rising-edge clock
//   bus    : p_multiplier_if.slave (input_ready, a, b, output_ready, product)
//   reset  : asynchronous active-low reset; aborts any operation at once
// Flow: IDLE --input_ready--> BUSY (WIDTH steps) --> DONE, held while
// input_ready stays high; a low input_ready returns to IDLE, so a
// continuously asserted request yields exactly one computation.
// Macro P_MULT_SIGNED_EN: two's complement arithmetic (see p_mult_datapath).
// ----------------------------------------------------------------------------
module p_multiplier
  import p_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  p_multiplier_if.slave    bus,
  input  logic             reset
);

  state_t r_state;
  state_t w_next_state;
  logic   r_out_ready;
  logic   w_start;
  logic   w_step;
  logic   w_last;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.input_ready) begin
          w_start      = 1'b1;
          w_next_state = BUSY;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = BUSY;
        end
      end
      DONE: begin
        if (bus.input_ready) begin
          w_next_state = DONE;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Registered valid flag, high exactly while the FSM sits in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_ready <= 1'b0;
    end else begin
      r_out_ready <= (w_next_state == DONE);
    end
  end

  p_mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_step    (w_step),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_last    (w_last),
    .o_product (bus.product)
  );

  assign bus.output_ready = r_out_ready;

endmodule

// File: tb/tb_p_multiplier.sv
// ----------------------------------------------------------------------------
// tb_p_multiplier
// Directed self-checking bench for p_multiplier (WIDTH = 8).
// Build with +define+P_MULT_SIGNED_EN to exercise the two's complement vectors.
// ----------------------------------------------------------------------------
module tb_p_multiplier;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  p_multiplier_if #(.WIDTH(8)) bus ();

  p_multiplier #(.WIDTH(8)) dut (
    .clk   (clk),
    .bus   (bus),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One pulsed operation: checks exact latency, held old product while busy,
  // the result on DONE entry and the return to IDLE with the product kept.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] exp, input logic [15:0] prev);
    bus.a           = va;
    bus.b           = vb;
    bus.input_ready = 1'b1;
    tick();
    bus.input_ready = 1'b0;
    repeat (7) tick();
    check({tag, "_rdy_at7"}, {15'd0, bus.output_ready}, 16'd0);
    check({tag, "_hold_at7"}, bus.product, prev);
    tick();
    check({tag, "_rdy_at8"}, {15'd0, bus.output_ready}, 16'd1);
    check({tag, "_prod"}, bus.product, exp);
    tick();
    check({tag, "_rdy_idle"}, {15'd0, bus.output_ready}, 16'd0);
    check({tag, "_prod_idle"}, bus.product, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset held with a start request and max operands present.
    reset           = 1'b0;
    bus.input_ready = 1'b1;
    bus.a           = 8'hFF;
    bus.b           = 8'hFF;
    repeat (3) tick();
    check("rst_rdy", {15'd0, bus.output_ready}, 16'd0);
    check("rst_prod", bus.product, 16'd0);
    reset           = 1'b1;
    bus.input_ready = 1'b0;
    tick();

    run_op("3x5", 8'd3, 8'd5, 16'd15, 16'd0);
`ifndef P_MULT_SIGNED_EN
    run_op("255x255", 8'd255, 8'd255, 16'hFE01, 16'd15);
    run_op("0x200", 8'd0, 8'd200, 16'd0, 16'hFE01);
`else
    run_op("0x200", 8'd0, 8'd200, 16'd0, 16'd15);
`endif

    // Level handshake: input_ready held for 30 cycles, operands wiggled.
    bus.a           = 8'd7;
    bus.b           = 8'd9;
    bus.input_ready = 1'b1;
    tick();
    repeat (2) tick();
    bus.a = 8'h55;
    bus.b = 8'hAA;
    repeat (6) tick();
    check("lvl_rdy_at8", {15'd0, bus.output_ready}, 16'd1);
    check("lvl_prod", bus.product, 16'd63);
    bus.a = 8'h12;
    bus.b = 8'h34;
    repeat (21) tick();
    check("lvl_rdy_held", {15'd0, bus.output_ready}, 16'd1);
    check("lvl_prod_held", bus.product, 16'd63);
    bus.input_ready = 1'b0;
    tick();
    check("lvl_rdy_drop", {15'd0, bus.output_ready}, 16'd0);
    check("lvl_prod_drop", bus.product, 16'd63);

    // Back-to-back with a one-cycle gap.
    run_op("12x12", 8'd12, 8'd12, 16'd144, 16'd63);
    run_op("13x11", 8'd13, 8'd11, 16'd143, 16'd144);

    // Reset mid-BUSY, asserted between clock edges.
    bus.a           = 8'd5;
    bus.b           = 8'd5;
    bus.input_ready = 1'b1;
    tick();
    bus.input_ready = 1'b0;
    repeat (3) tick();
    #1;
    reset = 1'b0;
    #1;
    check("midrst_rdy", {15'd0, bus.output_ready}, 16'd0);
    check("midrst_prod", bus.product, 16'd0);
    tick();
    reset = 1'b1;
    tick();
    run_op("6x7", 8'd6, 8'd7, 16'd42, 16'd0);

`ifdef P_MULT_SIGNED_EN
    run_op("s_m128xm128", 8'h80, 8'h80, 16'h4000, 16'd42);
    run_op("s_m1x1", 8'hFF, 8'h01, 16'hFFFF, 16'h4000);
    run_op("s_127xm128", 8'h7F, 8'h80, 16'hC080, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
